// File: rtl/if_id_skid.sv
// if_id_skid -- IF/ID pipeline register with a 2-entry skid buffer.
//
// Carries fetch results (pc, inst) from IF to ID. The main register
// drives the ID side. The skid register catches the one entry that IF
// can still push in the cycle ID stalls. in_ready comes straight from
// a flop, so ID back-pressure never forms a combinational path to IF.
// A synchronous flush discards everything held, plus any input offered
// in the same cycle. flush_cnt saturates and counts the entries lost
// this way.
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both 1 (in_valid/in_ready on the IF side, out_valid/out_ready
// on the ID side). A producer holding valid keeps its payload stable
// until the transfer. out_pc/out_inst never change while out_valid=1 and
// out_ready=0.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   flush      synchronous discard of held and incoming entries
//   in_valid   IF offers in_pc/in_inst
//   in_ready   stage can accept (registered)
//   in_pc      IF instruction address
//   in_inst    IF instruction
//   out_valid  ID-side entry valid
//   out_ready  ID accepts the entry
//   out_pc     ID instruction address (RESET_PC when empty)
//   out_inst   ID instruction (NOP_INST when empty)
//   flush_cnt  saturating count of valid entries discarded by flush
//   dbg_state  occupancy state: 0 EMPTY, 1 ONE, 2 TWO
module if_id_skid #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [INST_W-1:0]  NOP_INST = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst;

  logic main_v;
  logic skid_v;
  logic in_fire;
  logic out_fire;

  // Both valid bits are decoded from the state register. The illegal
  // combination (skid valid with main empty) has no encoding.
  assign main_v   = (state != EMPTY);
  assign skid_v   = (state == TWO);
  assign out_valid = main_v;
  assign dbg_state = state;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Flush accounting. An entry that ID takes in the flush cycle counts
  // as delivered, not as flushed. The sum gets two extra bits so the
  // saturation compare cannot overflow, even for a narrow counter.
  logic [1:0]       flush_add;
  logic [CNT_W+1:0] cnt_sum;
  logic [CNT_W+1:0] cnt_max;
  logic [CNT_W-1:0] cnt_next;

  assign flush_add = {1'b0, main_v & ~out_fire} + {1'b0, skid_v};
  assign cnt_sum   = {2'b00, flush_cnt} + {{CNT_W{1'b0}}, flush_add};
  assign cnt_max   = {2'b00, {CNT_W{1'b1}}};
  assign cnt_next  = (cnt_sum > cnt_max) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_pc    <= RESET_PC;
      out_inst  <= NOP_INST;
      skid_pc   <= '0;
      skid_inst <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      // Flush wins over every handshake. Any input offered in this
      // cycle is dropped.
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_pc    <= RESET_PC;
      out_inst  <= NOP_INST;
      skid_pc   <= '0;
      skid_inst <= '0;
      flush_cnt <= cnt_next;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            out_pc   <= in_pc;
            out_inst <= in_inst;
            state    <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            // Full throughput: the new entry replaces the delivered one.
            out_pc   <= in_pc;
            out_inst <= in_inst;
          end else if (in_fire) begin
            // ID stalled. Park the new entry in the skid register and
            // stop accepting from the next cycle on.
            skid_pc   <= in_pc;
            skid_inst <= in_inst;
            state     <= TWO;
            in_ready  <= 1'b0;
          end else if (out_fire) begin
            out_pc   <= RESET_PC;
            out_inst <= NOP_INST;
            state    <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is 0 here, so only the ID side can make progress.
          if (out_fire) begin
            out_pc   <= skid_pc;
            out_inst <= skid_inst;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
          out_pc   <= RESET_PC;
          out_inst <= NOP_INST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// tb_if_id_skid -- self-checking bench for if_id_skid.
//
// Two instances share all inputs. dut uses a 16-bit flush counter.
// dut_sat uses a 2-bit counter so that saturation is reached. The
// reference is a bounded FIFO queue of at most two entries, plus an
// integer flush tally. The bench checks both instances against it on
// every falling edge. Directed vectors come from a table. Async reset
// and random traffic follow.
module tb_if_id_skid;
  localparam logic [31:0] R_PC = 32'h0000_fff0;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_inst;
  logic [15:0] flush_cnt;
  logic [1:0]  dbg_state;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_pc, s_out_inst;
  logic [1:0]  s_flush_cnt;
  logic [1:0]  s_dbg_state;

  always #5 clk = ~clk;

  if_id_skid #(.ADDR_W(32), .INST_W(32), .RESET_PC(R_PC), .NOP_INST(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  if_id_skid #(.ADDR_W(32), .INST_W(32), .RESET_PC(R_PC), .NOP_INST(NOP), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_out_pc), .out_inst(s_out_inst), .flush_cnt(s_flush_cnt), .dbg_state(s_dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t mq[$];          // entries held by the stage, oldest first
  int   m_cnt = 0;      // valid entries discarded by flush, unbounded
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Compare both instances against the queue model.
  task automatic check_model();
    logic        e_v, e_r;
    logic [31:0] e_pc, e_inst;
    e_v    = (mq.size() > 0);
    e_r    = (mq.size() < 2);
    e_pc   = e_v ? mq[0].pc : R_PC;
    e_inst = e_v ? mq[0].inst : NOP;
    chk("out_valid", out_valid, e_v);
    chk("in_ready", in_ready, e_r);
    chk("out_pc", out_pc, e_pc);
    chk("out_inst", out_inst, e_inst);
    chk("flush_cnt", flush_cnt, sat(m_cnt, 65535));
    chk("dbg_state", dbg_state, mq.size());
    chk("sat_out_valid", s_out_valid, e_v);
    chk("sat_in_ready", s_in_ready, e_r);
    chk("sat_out_pc", s_out_pc, e_pc);
    chk("sat_out_inst", s_out_inst, e_inst);
    chk("sat_flush_cnt", s_flush_cnt, sat(m_cnt, 3));
  endtask

  // Apply one clock edge to the model using the inputs present at the edge.
  task automatic model_step(input logic f, input logic iv, input logic [31:0] pc,
                            input logic [31:0] inst, input logic ordy);
    bit   ofire, ifire;
    ent_t e;
    ofire = (mq.size() > 0) && ordy;
    ifire = iv && (mq.size() < 2);
    if (f) begin
      m_cnt += mq.size() - (ofire ? 1 : 0);
      mq.delete();
    end else begin
      if (ofire) void'(mq.pop_front());
      if (ifire) begin
        e.pc = pc;
        e.inst = inst;
        mq.push_back(e);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic f, input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic ordy);
    flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    @(posedge clk);
    model_step(f, iv, pc, inst, ordy);
    @(negedge clk);
    check_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        f, iv;
    logic [31:0] pc, inst;
    logic        ordy;
    logic        e_v, e_r;
    logic [31:0] e_pc, e_inst;
    int          e_cnt, e_sat;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic f, input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic ordy, input logic e_v, input logic e_r, input logic [31:0] e_pc,
                     input logic [31:0] e_inst, input int e_cnt, input int e_sat);
    vec_t v;
    v.f = f; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
    v.e_v = e_v; v.e_r = e_r; v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_cnt = e_cnt; v.e_sat = e_sat;
    vt.push_back(v);
  endtask

  initial begin
    // Reset held for 3 cycles with IF trying to push.
    in_valid = 1'b1; in_pc = 32'h0000_0aa0; in_inst = 32'h0bad_0bad;
    repeat (3) @(negedge clk);
    check_model();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_model();

    // Streaming, full throughput, 1-cycle latency.
    add(0, 1, 32'h0,   32'h34010001, 1,  1, 1, 32'h0,   32'h34010001, 0, 0);
    add(0, 1, 32'h4,   32'h34010002, 1,  1, 1, 32'h4,   32'h34010002, 0, 0);
    add(0, 1, 32'h8,   32'h34010003, 1,  1, 1, 32'h8,   32'h34010003, 0, 0);
    add(0, 1, 32'hC,   32'h34010004, 1,  1, 1, 32'hC,   32'h34010004, 0, 0);
    add(0, 0, 32'h0,   32'h0,        1,  0, 1, R_PC,    NOP,          0, 0);
    // Back-pressure: fill both entries, offer a third that must be ignored.
    add(0, 1, 32'h100, 32'hA0,       0,  1, 1, 32'h100, 32'hA0,       0, 0);
    add(0, 1, 32'h104, 32'hA1,       0,  1, 0, 32'h100, 32'hA0,       0, 0);
    add(0, 1, 32'h108, 32'hA2,       0,  1, 0, 32'h100, 32'hA0,       0, 0);
    add(0, 0, 32'h0,   32'h0,        1,  1, 1, 32'h104, 32'hA1,       0, 0);
    add(0, 0, 32'h0,   32'h0,        1,  0, 1, R_PC,    NOP,          0, 0);
    // Flush in TWO with a simultaneous input: two entries counted, input dropped.
    add(0, 1, 32'h110, 32'hB0,       0,  1, 1, 32'h110, 32'hB0,       0, 0);
    add(0, 1, 32'h114, 32'hB1,       0,  1, 0, 32'h110, 32'hB0,       0, 0);
    add(1, 1, 32'h200, 32'hC0,       0,  0, 1, R_PC,    NOP,          2, 2);
    // Flush during a dequeue: delivered entry not counted.
    add(0, 1, 32'h204, 32'hC1,       0,  1, 1, 32'h204, 32'hC1,       2, 2);
    add(1, 0, 32'h0,   32'h0,        1,  0, 1, R_PC,    NOP,          2, 2);
    // Saturation of the 2-bit counter.
    add(0, 1, 32'h208, 32'hC2,       0,  1, 1, 32'h208, 32'hC2,       2, 2);
    add(1, 0, 32'h0,   32'h0,        0,  0, 1, R_PC,    NOP,          3, 3);
    add(0, 1, 32'h20C, 32'hC3,       0,  1, 1, 32'h20C, 32'hC3,       3, 3);
    add(1, 0, 32'h0,   32'h0,        0,  0, 1, R_PC,    NOP,          4, 3);

    foreach (vt[i]) begin
      cycle(vt[i].f, vt[i].iv, vt[i].pc, vt[i].inst, vt[i].ordy);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].e_v);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vt[i].e_r);
      chk($sformatf("vec%0d_out_pc", i), out_pc, vt[i].e_pc);
      chk($sformatf("vec%0d_out_inst", i), out_inst, vt[i].e_inst);
      chk($sformatf("vec%0d_flush_cnt", i), flush_cnt, vt[i].e_cnt);
      chk($sformatf("vec%0d_sat_cnt", i), s_flush_cnt, vt[i].e_sat);
    end

    // Async reset between edges while in TWO.
    cycle(0, 1, 32'h300, 32'hD0, 0);
    cycle(0, 1, 32'h304, 32'hD1, 0);
    chk("pre_reset_state", dbg_state, 2);
    in_valid = 1'b1; in_pc = 32'h400; in_inst = 32'hE0; out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_out_pc", out_pc, R_PC);
    chk("async_out_inst", out_inst, NOP);
    chk("async_flush_cnt", flush_cnt, 0);
    chk("async_sat_cnt", s_flush_cnt, 0);
    mq.delete();
    m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    check_model();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle(0, 1, 32'h500, 32'hF0, 0);
    chk("post_reset_latency_valid", out_valid, 1);
    chk("post_reset_latency_pc", out_pc, 32'h500);

    // Randomised traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      logic        f, iv, ordy;
      logic [31:0] pc, inst;
      f    = ($urandom_range(15) == 0);
      iv   = ($urandom_range(3) != 0);
      ordy = ($urandom_range(2) != 0);
      pc   = $urandom;
      inst = $urandom;
      cycle(f, iv, pc, inst, ordy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
